// File: rtl/bus_master_if_pkg.sv
// Shared bus constants: direction encodings, active-low levels and default widths.
package bus_master_if_pkg;

    // Bus direction encodings
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low control levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Default bus widths (word addressed)
    localparam int unsigned BUS_ADDR_W = 30;
    localparam int unsigned BUS_DATA_W = 32;

endpackage

// File: rtl/bus_master_if.sv
// Requester side of the shared bus: turns one core access into
// request -> grant -> single strobed cycle -> ready/timeout -> release,
// stalling the core for the whole access.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned ADDR_W  = BUS_ADDR_W,
    parameter int unsigned DATA_W  = BUS_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    // Core side
    input  logic              core_as,
    input  logic              core_rw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wr_data,
    input  logic              core_flush,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              bus_err,
    // Bus side
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    // Guard against a zero-width counter when TIMEOUT is 0
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StAccess,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Core request captured in IDLE so the core may not need to keep it stable
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic              rw_lat_q, rw_lat_d;
    logic [DATA_W-1:0] wdata_lat_q, wdata_lat_d;
    // Registered bus and core outputs
    logic              bus_req_q, bus_req_d;
    logic              bus_as_q, bus_as_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_rw_q, bus_rw_d;
    logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              bus_err_q, bus_err_d;

    // Next-state and next-output logic for the access sequence
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_lat_d    = addr_lat_q;
        rw_lat_d      = rw_lat_q;
        wdata_lat_d   = wdata_lat_q;
        bus_req_d     = bus_req_q;
        bus_as_d      = bus_as_q;
        bus_addr_d    = bus_addr_q;
        bus_rw_d      = bus_rw_q;
        bus_wr_data_d = bus_wr_data_q;
        rd_data_d     = rd_data_q;
        bus_err_d     = bus_err_q;

        unique case (state_q)
            StIdle: begin
                if (core_as && !core_flush) begin
                    addr_lat_d  = core_addr;
                    rw_lat_d    = core_rw;
                    wdata_lat_d = core_wr_data;
                    bus_req_d   = ENABLE_;
                    state_d     = StReq;
                end
            end

            StReq: begin
                // Flush wins over a grant arriving in the same cycle
                if (core_flush) begin
                    bus_req_d = DISABLE_;
                    state_d   = StIdle;
                end else if (bus_grnt_ == ENABLE_) begin
                    bus_addr_d    = addr_lat_q;
                    bus_rw_d      = rw_lat_q;
                    bus_wr_data_d = wdata_lat_q;
                    bus_as_d      = ENABLE_;
                    cnt_d         = '0;
                    state_d       = StAccess;
                end
            end

            StAccess: begin
                bus_as_d = DISABLE_;
                if (bus_rdy_ == ENABLE_ || cnt_q == CNT_MAX) begin
                    // Ready on the last counted cycle still counts as success
                    if (bus_rdy_ == ENABLE_) begin
                        if (rw_lat_q == READ) begin
                            rd_data_d = bus_rd_data;
                        end
                    end else begin
                        bus_err_d = 1'b1;
                        if (rw_lat_q == READ) begin
                            rd_data_d = '0;
                        end
                    end
                    bus_req_d     = DISABLE_;
                    bus_addr_d    = '0;
                    bus_rw_d      = READ;
                    bus_wr_data_d = '0;
                    state_d       = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                bus_err_d = 1'b0;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_lat_q    <= '0;
            rw_lat_q      <= READ;
            wdata_lat_q   <= '0;
            bus_req_q     <= DISABLE_;
            bus_as_q      <= DISABLE_;
            bus_addr_q    <= '0;
            bus_rw_q      <= READ;
            bus_wr_data_q <= '0;
            rd_data_q     <= '0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_lat_q    <= addr_lat_d;
            rw_lat_q      <= rw_lat_d;
            wdata_lat_q   <= wdata_lat_d;
            bus_req_q     <= bus_req_d;
            bus_as_q      <= bus_as_d;
            bus_addr_q    <= bus_addr_d;
            bus_rw_q      <= bus_rw_d;
            bus_wr_data_q <= bus_wr_data_d;
            rd_data_q     <= rd_data_d;
            bus_err_q     <= bus_err_d;
        end
    end

    // The core is released only in the single DONE cycle
    assign stall       = core_as && (state_q != StDone);
    assign rd_data     = rd_data_q;
    assign bus_err     = bus_err_q;
    assign bus_req_    = bus_req_q;
    assign bus_as_     = bus_as_q;
    assign bus_addr    = bus_addr_q;
    assign bus_rw      = bus_rw_q;
    assign bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Self-checking bench for bus_master_if: directed scenarios plus randomized
// accesses checked against a cycle-count/data model of the access sequence.
module tb_bus_master_if;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int          TO     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              core_as = 1'b0;
    logic              core_rw = 1'b1;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_wr_data = '0;
    logic              core_flush = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              stall;
    logic              bus_err;
    logic              bus_req_;
    logic              bus_grnt_ = 1'b1;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data = '0;
    logic              bus_rdy_ = 1'b1;

    bus_master_if #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_as     (core_as),
        .core_rw     (core_rw),
        .core_addr   (core_addr),
        .core_wr_data(core_wr_data),
        .core_flush  (core_flush),
        .rd_data     (rd_data),
        .stall       (stall),
        .bus_err     (bus_err),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_addr    (bus_addr),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the rd_data register
    logic [DATA_W-1:0] exp_rd = '0;

    // Observations of the last access
    int                r_done;
    int                r_as;
    int                r_as_cyc;
    int                r_err;
    logic              r_req_ok;
    logic              r_hold_ok;
    logic              r_req_done;
    logic [DATA_W-1:0] r_rd;

    // Model: ACCESS lasts until ready, or TO+1 cycles when the slave never answers
    function automatic int exp_alen(input int w);
        return (w > TO) ? TO + 1 : w + 1;
    endfunction

    // Cycle index of DONE counted from the IDLE cycle that sees core_as
    function automatic int exp_done(input int g, input int w);
        return 1 + (g + 1) + exp_alen(w);
    endfunction

    // Drives one access; the arbiter grants on the (g+1)th request cycle and
    // the slave answers on ACCESS cycle w (never, if w exceeds the timeout).
    task automatic run_access(input logic rw, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdv,
                              input int g, input int w, input logic hold);
        int req_idx;
        int acc_idx;
        core_as      = 1'b1;
        core_rw      = rw;
        core_addr    = addr;
        core_wr_data = wd;
        bus_rd_data  = rdv;
        bus_grnt_    = 1'b1;
        bus_rdy_     = 1'b1;
        r_done = -1; r_as = 0; r_as_cyc = -1; r_err = 0;
        r_req_ok = 1'b1; r_hold_ok = 1'b1; r_req_done = 1'b0; r_rd = '0;
        req_idx = -1;
        acc_idx = -1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (bus_err === 1'b1) r_err++;
            if (stall === 1'b0) begin
                r_done     = cyc;
                r_rd       = rd_data;
                r_req_done = bus_req_;
                core_as    = hold;
                bus_grnt_  = 1'b1;
                bus_rdy_   = 1'b1;
                @(negedge clk);
                break;
            end
            if (cyc == 0 ? (bus_req_ !== 1'b1) : (bus_req_ !== 1'b0)) r_req_ok = 1'b0;
            if (bus_as_ === 1'b0) begin
                r_as++;
                if (r_as_cyc < 0) r_as_cyc = cyc;
                acc_idx = 0;
            end else if (acc_idx >= 0) begin
                acc_idx++;
            end
            if (acc_idx >= 0 &&
                (bus_addr !== addr || bus_rw !== rw || bus_wr_data !== wd)) r_hold_ok = 1'b0;
            if (bus_req_ === 1'b0 && acc_idx < 0) req_idx++;
            bus_grnt_ = (bus_req_ === 1'b0 && (acc_idx >= 0 || req_idx >= g)) ? 1'b0 : 1'b1;
            bus_rdy_  = (acc_idx == w) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        if (r_done < 0) core_as = 1'b0;
    endtask

    task automatic test_reset();
        core_as = 1'b0;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_=%b as_=%b, expected 1 1", bus_req_, bus_as_);
        end
        n_tests++;
        if (bus_addr !== '0 || bus_wr_data !== '0 || bus_rw !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_bus: addr=%0h wd=%0h rw=%b, expected 0 0 1",
                     bus_addr, bus_wr_data, bus_rw);
        end
        n_tests++;
        if (rd_data !== '0 || bus_err !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_core: rd=%0h err=%b stall=%b, expected 0 0 0",
                     rd_data, bus_err, stall);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        run_access(1'b1, 30'h1234, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        exp_rd = 32'hDEADBEEF;
        n_tests++;
        if (r_done !== 3) begin
            n_fail++;
            $display("FAIL read_stall: DONE at cycle %0d, expected 3", r_done);
        end
        n_tests++;
        if (r_as !== 1 || r_as_cyc !== 2 || r_hold_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL read_strobe: pulses=%0d at %0d addr_ok=%b, expected 1 at 2 ok=1",
                     r_as, r_as_cyc, r_hold_ok);
        end
        n_tests++;
        if (r_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL read_data: rd_data=%0h, expected %0h", r_rd, exp_rd);
        end
        n_tests++;
        if (r_req_done !== 1'b1 || r_req_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL read_req: req_ at DONE=%b seq_ok=%b, expected 1 1",
                     r_req_done, r_req_ok);
        end
    endtask

    task automatic test_write_delayed();
        run_access(1'b0, 30'h10, 32'hA5A5A5A5, 32'h0BADF00D, 5, 2, 1'b0);
        n_tests++;
        if (r_done !== 10) begin
            n_fail++;
            $display("FAIL write_stall: DONE at cycle %0d, expected 10", r_done);
        end
        n_tests++;
        if (r_req_ok !== 1'b1 || r_hold_ok !== 1'b1 || r_as !== 1) begin
            n_fail++;
            $display("FAIL write_bus: req_ok=%b hold_ok=%b pulses=%0d, expected 1 1 1",
                     r_req_ok, r_hold_ok, r_as);
        end
        n_tests++;
        if (r_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL write_rd_kept: rd_data=%0h, expected %0h", r_rd, exp_rd);
        end
    endtask

    task automatic test_flush();
        int as_seen;
        as_seen      = 0;
        core_as      = 1'b1;
        core_rw      = 1'b0;
        core_addr    = 30'h55;
        core_wr_data = 32'h11112222;
        bus_grnt_    = 1'b1;
        bus_rdy_     = 1'b0; // stray ready before ACCESS must be ignored
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            #1;
            if (bus_as_ === 1'b0) as_seen++;
            if (cyc == 3) begin
                n_tests++;
                if (bus_req_ !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_req_held: req_=%b in 3rd REQ cycle, expected 0", bus_req_);
                end
                core_flush = 1'b1;
                bus_grnt_  = 1'b0;
            end else if (cyc == 4) begin
                n_tests++;
                if (bus_req_ !== 1'b1) begin
                    n_fail++;
                    $display("FAIL flush_release: req_=%b after flush, expected 1", bus_req_);
                end
                core_as    = 1'b0;
                core_flush = 1'b0;
                bus_grnt_  = 1'b1;
                bus_rdy_   = 1'b1;
            end
        end
        n_tests++;
        if (as_seen !== 0 || bus_req_ !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: as_pulses=%0d req_=%b stall=%b, expected 0 1 0",
                     as_seen, bus_req_, stall);
        end
        n_tests++;
        if (rd_data !== exp_rd) begin
            n_fail++;
            $display("FAIL flush_rd_kept: rd_data=%0h, expected %0h", rd_data, exp_rd);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 30'h2000, 32'h0, 32'hFFFFFFFF, 0, 1000, 1'b0);
        exp_rd = '0;
        n_tests++;
        if (r_done !== exp_done(0, 1000)) begin
            n_fail++;
            $display("FAIL timeout_exit: DONE at cycle %0d, expected %0d",
                     r_done, exp_done(0, 1000));
        end
        n_tests++;
        if (r_err !== 1 || r_rd !== exp_rd || r_req_done !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_done: err_cycles=%0d rd=%0h req_=%b, expected 1 0 1",
                     r_err, r_rd, r_req_done);
        end
        #1;
        n_tests++;
        if (bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_pulse: bus_err=%b after DONE, expected 0", bus_err);
        end
        run_access(1'b1, 30'h2004, 32'h0, 32'h600DCAFE, 1, 1, 1'b0);
        exp_rd = 32'h600DCAFE;
        n_tests++;
        if (r_done !== exp_done(1, 1) || r_rd !== exp_rd || r_err !== 0) begin
            n_fail++;
            $display("FAIL timeout_recover: done=%0d rd=%0h err=%0d, expected %0d %0h 0",
                     r_done, r_rd, r_err, exp_done(1, 1), exp_rd);
        end
    endtask

    task automatic test_reset_mid();
        int as_seen;
        as_seen      = 0;
        core_as      = 1'b1;
        core_rw      = 1'b1;
        core_addr    = 30'h3ABC;
        core_wr_data = 32'h77777777;
        bus_rd_data  = 32'h12345678;
        bus_grnt_    = 1'b0;
        bus_rdy_     = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (bus_as_ === 1'b0) as_seen++;
        end
        n_tests++;
        if (as_seen !== 1) begin
            n_fail++;
            $display("FAIL rstmid_reach_access: as_pulses=%0d, expected 1", as_seen);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || bus_addr !== '0 || bus_rw !== 1'b1 ||
            bus_wr_data !== '0 || rd_data !== '0 || bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: req_=%b as_=%b addr=%0h rw=%b wd=%0h rd=%0h err=%b, expected 1 1 0 1 0 0 0",
                     bus_req_, bus_as_, bus_addr, bus_rw, bus_wr_data, rd_data, bus_err);
        end
        reset     = 1'b0;
        core_as   = 1'b0;
        bus_grnt_ = 1'b1;
        bus_rdy_  = 1'b0;
        @(negedge clk);
        #1;
        exp_rd = '0;
        n_tests++;
        if (rd_data !== exp_rd || stall !== 1'b0 || bus_req_ !== 1'b1 || bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_rdy_ignored: rd=%0h stall=%b req_=%b err=%b, expected 0 0 1 0",
                     rd_data, stall, bus_req_, bus_err);
        end
        bus_rdy_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 30'h100, 32'h0, 32'hCAFEF00D, 0, 0, 1'b1);
        n_tests++;
        if (r_done !== 3 || r_as !== 1 || r_rd !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL b2b_first: done=%0d pulses=%0d rd=%0h, expected 3 1 cafef00d",
                     r_done, r_as, r_rd);
        end
        // Continues straight from the IDLE cycle after DONE with core_as still high
        run_access(1'b1, 30'h104, 32'h0, 32'hBEEFBEEF, 0, 0, 1'b0);
        exp_rd = 32'hBEEFBEEF;
        n_tests++;
        if (r_done !== 3 || r_as !== 1 || r_rd !== exp_rd || r_req_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: done=%0d pulses=%0d rd=%0h req_ok=%b, expected 3 1 %0h 1",
                     r_done, r_as, r_rd, r_req_ok, exp_rd);
        end
    endtask

    task automatic test_random();
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] rdv;
        logic              hold;
        int                g;
        int                w;
        int                e_done;
        int                e_err;
        for (int i = 0; i < 24; i++) begin
            rw   = 1'($urandom_range(0, 1));
            addr = ADDR_W'($urandom);
            wd   = $urandom;
            rdv  = $urandom;
            g    = int'($urandom_range(0, 4));
            w    = int'($urandom_range(0, 6));
            hold = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
            e_done = exp_done(g, w);
            e_err  = (w > TO) ? 1 : 0;
            if (rw) exp_rd = (w > TO) ? '0 : rdv;
            run_access(rw, addr, wd, rdv, g, w, hold);
            n_tests++;
            if (r_done !== e_done || r_err !== e_err) begin
                n_fail++;
                $display("FAIL rand%0d_timing: done=%0d err=%0d, expected %0d %0d (g=%0d w=%0d)",
                         i, r_done, r_err, e_done, e_err, g, w);
            end
            n_tests++;
            if (r_rd !== exp_rd) begin
                n_fail++;
                $display("FAIL rand%0d_data: rd_data=%0h, expected %0h", i, r_rd, exp_rd);
            end
            n_tests++;
            if (r_as !== 1 || r_as_cyc !== g + 2 || r_hold_ok !== 1'b1 || r_req_ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_bus: pulses=%0d at %0d hold=%b req=%b, expected 1 at %0d 1 1",
                         i, r_as, r_as_cyc, r_hold_ok, r_req_ok, g + 2);
            end
        end
        core_as = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_delayed();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
